// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the FPGA-initiated SPI master.
package spi_pkg;

  localparam int SLV_IDX_W = 3;

  // SPI mode 0: CPOL=0, CPHA=0. Bit 1 of the mode is CPOL, the SCLK idle level.
  localparam logic [1:0] SPI_MODE  = 2'b00;
  localparam logic       SCLK_IDLE = SPI_MODE[1];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_master_tx_clk_gen.sv
// SCLK half-period generator: toggles SCLK every CLK_HALF enabled cycles and
// flags whether this cycle's toggle leaves or returns to the idle level.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          toggle;

  assign toggle = en_i && !clr_i && (cnt_q == CW'(CLK_HALF - 1));
  assign rise_o = toggle && (sclk_q == SCLK_IDLE);
  assign fall_o = toggle && (sclk_q != SCLK_IDLE);
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = SCLK_IDLE;
    end else if (en_i) begin
      if (toggle) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= SCLK_IDLE;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// Single-byte SPI master (mode 0) to one of NUM_SLAVES slaves. Every output
// comes straight from a register so nothing combinational reaches the pins.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int NUM_SLAVES = 7,
  parameter int DATA_W     = 8,
  parameter int CLK_HALF   = 2,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [SLV_IDX_W-1:0]  slave_sel,
  input  logic [DATA_W-1:0]     tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sel_err,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  output logic [NUM_SLAVES-1:0] spi_cs,
  input  logic [NUM_SLAVES-1:0] spi_miso
);

  localparam int BW   = $clog2(DATA_W + 1);
  localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = SLV_IDX_W + 1;

  spi_state_e             state_q, state_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SLV_IDX_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]      tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]      rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]      rx_q, rx_d;
  logic [NUM_SLAVES-1:0]  cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sel_err_q, sel_err_d;
  logic                   sel_ok;
  logic                   sclk_rise, sclk_fall;

  spi_clk_gen #(
    .CLK_HALF (CLK_HALF)
  ) u_clk_gen (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .en_i   (state_q == ST_XFER),
    .clr_i  (state_q != ST_XFER),
    .sclk_o (spi_clk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign sel_ok = ({1'b0, slave_sel} < SW'(NUM_SLAVES));

  // MOSI is the top of the TX shifter; zero-fill leaves it low once all bits are out.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    sel_d     = sel_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sel_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sel_ok) begin
            state_d          = ST_SETUP;
            sel_d            = slave_sel;
            tx_sh_d          = tx_data;
            rx_sh_d          = '0;
            bit_cnt_d        = '0;
            tmr_d            = '0;
            busy_d           = 1'b1;
            cs_d             = '1;
            cs_d[slave_sel]  = 1'b0;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q == TW'(CS_SETUP - 1)) begin
          state_d = ST_XFER;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso[sel_q]};
        end
        if (sclk_fall) begin
          tx_sh_d   = {tx_sh_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_q == TW'(CS_HOLD - 1)) begin
          state_d = ST_DONE;
          tmr_d   = '0;
          cs_d    = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      sel_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      cs_q      <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      sel_q     <= sel_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_err  = sel_err_q;
  assign rx_data  = rx_q;
  assign spi_mosi = tx_sh_q[DATA_W-1];
  assign spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: per-slave MISO models, a timeline-based reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_spi_master_tx;

  localparam int NS     = 7;
  localparam int W      = 8;
  localparam int HALF   = 2;
  localparam int SETUP  = 2;
  localparam int HOLD   = 2;
  localparam int RISE1  = SETUP + HALF;
  localparam int XEND   = SETUP + 2 * HALF * W;
  localparam int DONE_T = XEND + HOLD;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    slave_sel = '0;
  logic [W-1:0]  tx_data = '0;
  logic          busy, done, sel_err;
  logic [W-1:0]  rx_data;
  logic          spi_clk, spi_mosi;
  logic [NS-1:0] spi_cs;
  logic [NS-1:0] spi_miso = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int startCyc = 0;

  logic [W-1:0] misoPattern [NS];
  bit           noiseOn = 1'b0;
  int           riseCnt [NS];
  logic         slvPrevClk = 1'b0;

  int           t = -1;
  int           mSel = 0;
  logic [W-1:0] mTx = '0, mRx = '0, rxExp = '0;
  bit           selErrExp = 1'b0;
  bit           modelLive = 1'b0;

  int            sclkRises = 0, firstRiseCyc = -1, secondRiseCyc = -1, firstFallCyc = -1;
  int            donePulses = 0, csHighRun = 0, lastCsGap = 0;
  logic [W-1:0]  mosiCap = '0;
  logic [NS-1:0] csAnd = '1;
  logic          prevSclk = 1'b0;

  spi_master_tx #(
    .NUM_SLAVES (NS),
    .DATA_W     (W),
    .CLK_HALF   (HALF),
    .CS_SETUP   (SETUP),
    .CS_HOLD    (HOLD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .slave_sel (slave_sel),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .sel_err   (sel_err),
    .rx_data   (rx_data),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .spi_miso  (spi_miso)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: a transaction is a timeline t = edges since accept.
  always @(posedge sys_clk) begin
    cyc++;
    selErrExp = 1'b0;
    if (sys_rst) begin
      t = -1;
      rxExp = '0;
      modelLive = 1'b1;
    end else if (t >= 0) begin
      t = (t == DONE_T) ? -1 : t + 1;
      if (t == DONE_T) rxExp = mRx;
    end else if (start) begin
      if (int'(slave_sel) < NS) begin
        t = 0;
        mSel = int'(slave_sel);
        mTx = tx_data;
        mRx = misoPattern[slave_sel];
      end else begin
        selErrExp = 1'b1;
      end
    end
  end

  always @(negedge sys_clk) begin
    logic [NS-1:0] csExp;
    logic          clkExp, mosiExp;
    int            nf;
    if (modelLive) begin
      csExp   = (t >= 0 && t < DONE_T) ? ~(NS'(1) << mSel) : '1;
      clkExp  = (t >= RISE1 && t < XEND && ((t - RISE1) % (2 * HALF)) < HALF);
      mosiExp = 1'b0;
      if (t >= 0 && t < XEND) begin
        nf = (t < SETUP) ? 0 : (t - SETUP) / (2 * HALF);
        mosiExp = mTx[W-1-nf];
      end
      checkOutput("busy", 32'(busy), 32'(t >= 0 && t < DONE_T));
      checkOutput("done", 32'(done), 32'(t == DONE_T));
      checkOutput("sel_err", 32'(sel_err), 32'(selErrExp));
      checkOutput("rx_data", 32'(rx_data), 32'(rxExp));
      checkOutput("spi_cs", 32'(spi_cs), 32'(csExp));
      checkOutput("spi_clk", 32'(spi_clk), 32'(clkExp));
      checkOutput("spi_mosi", 32'(spi_mosi), 32'(mosiExp));
    end
  end

  // Slave models: shift out their pattern MSB first, advancing after each SCLK rise.
  always @(negedge sys_clk) begin
    for (int i = 0; i < NS; i++) begin
      if (spi_cs[i] !== 1'b0) begin
        riseCnt[i] = 0;
        spi_miso[i] = noiseOn ? 1'($urandom) : 1'b0;
      end else begin
        if (spi_clk === 1'b1 && slvPrevClk === 1'b0) riseCnt[i]++;
        spi_miso[i] = (riseCnt[i] < W) ? misoPattern[i][W-1-riseCnt[i]] : 1'b0;
      end
    end
    slvPrevClk = spi_clk;
  end

  always @(negedge sys_clk) begin
    if (spi_clk === 1'b1 && prevSclk === 1'b0) begin
      sclkRises++;
      mosiCap = {mosiCap[W-2:0], spi_mosi};
      if (sclkRises == 1) firstRiseCyc = cyc;
      else if (sclkRises == 2) secondRiseCyc = cyc;
    end
    if (spi_clk === 1'b0 && prevSclk === 1'b1 && firstFallCyc < 0) firstFallCyc = cyc;
    prevSclk = spi_clk;
    csAnd &= spi_cs;
    if (done === 1'b1) donePulses++;
    if (&spi_cs) csHighRun++;
    else begin
      if (csHighRun > 0) lastCsGap = csHighRun;
      csHighRun = 0;
    end
  end

  task automatic clearMon();
    sclkRises = 0;
    firstRiseCyc = -1;
    secondRiseCyc = -1;
    firstFallCyc = -1;
    donePulses = 0;
    mosiCap = '0;
    csAnd = '1;
  endtask

  // Called just after a posedge; holds start for exactly one sampling edge.
  task automatic applyStimulus(input logic [2:0] sel, input logic [W-1:0] tx);
    slave_sel = sel;
    tx_data = tx;
    start = 1'b1;
    startCyc = cyc;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    slave_sel = 3'($urandom);
    tx_data = W'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        lat = cyc - startCyc;
        break;
      end
    end
    if (lat < 0) checkOutput("doneTimeout", 0, 1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int sel;
    logic [W-1:0] tx, pat;
    for (int i = 0; i < NS; i++) misoPattern[i] = '0;

    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("resetRx", 32'(rx_data), 0);
    checkOutput("resetCs", 32'(spi_cs), 32'h7F);
    checkOutput("resetBusy", 32'(busy), 0);
    @(posedge sys_clk);
    #1;

    $display("[TB] basic transfer to slave 2");
    misoPattern[2] = 8'h3C;
    clearMon();
    applyStimulus(3'd2, 8'hA5);
    waitDone(lat);
    checkOutput("t1Latency", 32'(lat), 37);
    checkOutput("t1Rx", 32'(rx_data), 32'h3C);
    checkOutput("t1Mosi", 32'(mosiCap), 32'hA5);
    checkOutput("t1Cs", 32'(csAnd), 32'b1111011);

    $display("[TB] invalid slave index");
    @(posedge sys_clk);
    #1;
    clearMon();
    applyStimulus(3'd7, 8'h55);
    @(negedge sys_clk);
    checkOutput("t2SelErr", 32'(sel_err), 1);
    checkOutput("t2Busy", 32'(busy), 0);
    repeat (10) @(negedge sys_clk);
    checkOutput("t2NoSclk", 32'(sclkRises), 0);
    checkOutput("t2Cs", 32'(csAnd), 32'h7F);

    $display("[TB] start re-pulsed mid-transfer");
    @(posedge sys_clk);
    #1;
    misoPattern[1] = 8'hC3;
    clearMon();
    applyStimulus(3'd1, 8'h5A);
    repeat (12) @(posedge sys_clk);
    #1;
    slave_sel = 3'd4;
    tx_data = 8'hFF;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("t3Latency", 32'(lat), 37);
    checkOutput("t3Rx", 32'(rx_data), 32'hC3);
    checkOutput("t3Mosi", 32'(mosiCap), 32'h5A);
    checkOutput("t3Cs", 32'(csAnd), 32'b1111101);

    $display("[TB] reset after third SCLK rise");
    @(posedge sys_clk);
    #1;
    misoPattern[3] = 8'h96;
    clearMon();
    applyStimulus(3'd3, 8'h33);
    for (int i = 0; i < 60 && sclkRises < 3; i++) @(negedge sys_clk);
    checkOutput("t4ThirdRise", 32'(sclkRises), 3);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("t4Cs", 32'(spi_cs), 32'h7F);
    checkOutput("t4Clk", 32'(spi_clk), 0);
    checkOutput("t4Busy", 32'(busy), 0);
    checkOutput("t4Rx", 32'(rx_data), 0);
    repeat (40) @(negedge sys_clk);
    checkOutput("t4NoDone", 32'(donePulses), 0);
    @(posedge sys_clk);
    #1;
    misoPattern[0] = 8'h7E;
    applyStimulus(3'd0, 8'h81);
    waitDone(lat);
    checkOutput("t4RxAfter", 32'(rx_data), 32'h7E);

    $display("[TB] back-to-back transfers");
    @(posedge sys_clk);
    #1;
    misoPattern[6] = 8'hD2;
    misoPattern[0] = 8'h4B;
    applyStimulus(3'd6, 8'h0F);
    waitDone(lat);
    checkOutput("t5RxFirst", 32'(rx_data), 32'hD2);
    @(posedge sys_clk);
    #1;
    applyStimulus(3'd0, 8'hF0);
    waitDone(lat);
    checkOutput("t5Latency", 32'(lat), 37);
    checkOutput("t5RxSecond", 32'(rx_data), 32'h4B);
    checkOutput("t5CsGapAtLeast2", 32'(lastCsGap >= 2), 1);

    $display("[TB] noisy unselected MISO, slave 5");
    @(posedge sys_clk);
    #1;
    noiseOn = 1'b1;
    misoPattern[5] = 8'hFF;
    clearMon();
    applyStimulus(3'd5, 8'h00);
    waitDone(lat);
    checkOutput("t6Rx", 32'(rx_data), 32'hFF);
    checkOutput("t6Period", 32'(secondRiseCyc - firstRiseCyc), 4);
    checkOutput("t6HighTime", 32'(firstFallCyc - firstRiseCyc), 2);

    $display("[TB] randomized transfers");
    for (int k = 0; k < 12; k++) begin
      @(posedge sys_clk);
      #1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge sys_clk);
        #1;
      end
      sel = $urandom_range(0, 7);
      tx = W'($urandom);
      pat = W'($urandom);
      noiseOn = 1'($urandom);
      if (sel < NS) misoPattern[sel] = pat;
      applyStimulus(3'(sel), tx);
      if (sel < NS) begin
        waitDone(lat);
        checkOutput("randLatency", 32'(lat), 37);
        checkOutput("randRx", 32'(rx_data), 32'(pat));
      end else begin
        repeat (3) @(negedge sys_clk);
      end
    end

    repeat (4) @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
